// File: rtl/run_sequencer.sv
// Host-side run controller: parks the core, pulses init, issues a one-cycle req,
// then counts RUN cycles until ack, abort or timeout. Also muxes the DataMem port.
module run_sequencer #(
  parameter int unsigned W           = 8,
  parameter int unsigned CW          = 16,
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned MAX_CYCLES  = 50000
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  input  logic          abort,
  output logic          core_init,
  output logic          core_req,
  input  logic          core_ack,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_count,
  input  logic          host_we,
  input  logic [W-1:0]  host_addr,
  input  logic [W-1:0]  host_wdata,
  output logic          host_grant,
  input  logic          core_we,
  input  logic [W-1:0]  core_addr,
  input  logic [W-1:0]  core_wdata,
  output logic          mem_we,
  output logic [W-1:0]  mem_addr,
  output logic [W-1:0]  mem_wdata
);

  localparam int unsigned ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_REQ,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t          state_q, state_d;
  logic [ICW-1:0]  init_cnt_q, init_cnt_d;
  logic [CW-1:0]   cycle_q, cycle_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      init_cnt_q <= '0;
      cycle_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      cycle_q    <= cycle_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    cycle_d    = cycle_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start) begin
          state_d    = S_INIT;
          cycle_d    = '0;
          init_cnt_d = ICW'(INIT_CYCLES - 1);
        end
      end
      S_INIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (init_cnt_q == '0) begin
          state_d = S_REQ;
        end else begin
          init_cnt_d = init_cnt_q - 1'b1;
        end
      end
      S_REQ: begin
        state_d = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        // ack wins over the timeout check so a last-cycle ack still completes
        if (abort) begin
          state_d = S_IDLE;
        end else if (core_ack) begin
          state_d = S_DONE;
        end else if (cycle_q == CW'(MAX_CYCLES - 1)) begin
          state_d = S_TIMEOUT;
          cycle_d = CW'(MAX_CYCLES);
        end else begin
          cycle_d = cycle_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign core_init   = (state_q == S_INIT);
  assign core_req    = (state_q == S_REQ);
  assign busy        = (state_q == S_INIT) || (state_q == S_REQ) || (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign timeout     = (state_q == S_TIMEOUT);
  assign host_grant  = ~busy;
  assign cycle_count = cycle_q;

  assign mem_we    = host_grant ? host_we    : core_we;
  assign mem_addr  = host_grant ? host_addr  : core_addr;
  assign mem_wdata = host_grant ? host_wdata : core_wdata;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: a vector table for reset/arbitration basics,
// then hand-written sequences for runs, timeout, abort, reset and edge cases.
module tb_run_sequencer;

  localparam int unsigned W   = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned MAX = 100;

  logic          Clk = 1'b0;
  logic          Reset, start, abort, core_ack;
  logic          core_init, core_req, busy, done, timeout, host_grant;
  logic [CW-1:0] cycle_count;
  logic          host_we, core_we, mem_we;
  logic [W-1:0]  host_addr, host_wdata, core_addr, core_wdata, mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  run_sequencer #(.W(W), .CW(CW), .INIT_CYCLES(2), .MAX_CYCLES(MAX)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .abort(abort),
    .core_init(core_init), .core_req(core_req), .core_ack(core_ack),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_grant(host_grant),
    .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       rst, st, ab, ack, hwe;
    logic [7:0] haddr, hwd;
    logic       cwe;
    logic [7:0] caddr, cwd;
    logic       e_init, e_req, e_busy, e_done, e_to, e_grant, e_mwe;
    logic [7:0] e_maddr, e_mwd;
    logic [15:0] e_cc;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic in_run();
    return busy && !core_init && !core_req;
  endfunction

  int n_init, n_req, runs;
  logic aborted;

  initial begin
    Reset = 1'b1; start = 1'b0; abort = 1'b0; core_ack = 1'b0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    core_we = 1'b0; core_addr = '0; core_wdata = '0;

    //             rst st ab ack hwe haddr  hwd    cwe caddr  cwd    ini req bsy dne to  gnt mwe maddr  mwd    cc
    vecs[0] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,16'd0};
    vecs[1] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,16'd0};
    vecs[2] = '{1'b0,1'b0,1'b0,1'b0,1'b1,8'h10,8'hA5,1'b0,8'h00,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,8'h10,8'hA5,16'd0};
    vecs[3] = '{1'b0,1'b1,1'b0,1'b1,1'b1,8'h10,8'hA5,1'b0,8'h33,8'h44, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h33,8'h44,16'd0};
    vecs[4] = '{1'b0,1'b0,1'b0,1'b1,1'b1,8'h10,8'hA5,1'b0,8'h33,8'h44, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h33,8'h44,16'd0};
    vecs[5] = '{1'b0,1'b0,1'b0,1'b0,1'b1,8'h10,8'hA5,1'b0,8'h33,8'h44, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,8'h33,8'h44,16'd0};
    vecs[6] = '{1'b0,1'b0,1'b0,1'b0,1'b1,8'h10,8'hA5,1'b1,8'h20,8'h5A, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,8'h20,8'h5A,16'd0};
    vecs[7] = '{1'b0,1'b0,1'b0,1'b0,1'b1,8'h10,8'hA5,1'b0,8'h21,8'h5B, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'h21,8'h5B,16'd1};
    vecs[8] = '{1'b0,1'b0,1'b0,1'b1,1'b1,8'h10,8'hA5,1'b1,8'h20,8'h5A, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,8'h10,8'hA5,16'd1};
    vecs[9] = '{1'b0,1'b0,1'b1,1'b0,1'b0,8'h10,8'hA5,1'b1,8'h20,8'h5A, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,8'h10,8'hA5,16'd1};

    #2;
    for (int i = 0; i < 10; i++) begin
      Reset = vecs[i].rst; start = vecs[i].st; abort = vecs[i].ab; core_ack = vecs[i].ack;
      host_we = vecs[i].hwe; host_addr = vecs[i].haddr; host_wdata = vecs[i].hwd;
      core_we = vecs[i].cwe; core_addr = vecs[i].caddr; core_wdata = vecs[i].cwd;
      step();
      check($sformatf("vec%0d", i),
            {core_init, core_req, busy, done, timeout, host_grant, mem_we, mem_addr, mem_wdata, cycle_count},
            {vecs[i].e_init, vecs[i].e_req, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_to,
             vecs[i].e_grant, vecs[i].e_mwe, vecs[i].e_maddr, vecs[i].e_mwd, vecs[i].e_cc});
    end
    abort = 1'b0; core_ack = 1'b0; host_we = 1'b0; core_we = 1'b0;

    // normal run: ack after 37 RUN cycles, measure init/req pulse widths
    n_init = 0; n_req = 0; runs = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 200 && !(done || timeout); i++) begin
      if (core_init) n_init++;
      if (core_req) n_req++;
      if (in_run()) begin core_ack = (runs == 37); runs++; end
      step();
    end
    core_ack = 1'b0;
    check("run_done", done, 1'b1);
    check("run_timeout", timeout, 1'b0);
    check("run_init_width", n_init, 2);
    check("run_req_width", n_req, 1);
    check("run_cycles", cycle_count, 37);
    check("run_grant", host_grant, 1'b1);

    // timeout: ack never asserted
    runs = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 300 && !(done || timeout); i++) begin
      if (in_run()) runs++;
      step();
    end
    check("to_flag", timeout, 1'b1);
    check("to_done", done, 1'b0);
    check("to_cycles", cycle_count, MAX);
    check("to_run_len", runs, MAX);
    start = 1'b1; step(); start = 1'b0;
    check("to_restart", {timeout, core_init, host_grant, cycle_count}, {1'b0, 1'b1, 1'b0, 16'd0});

    // abort on the fifth RUN cycle of the restarted run
    runs = 0; aborted = 1'b0;
    for (int i = 0; i < 50 && !aborted; i++) begin
      if (in_run()) begin
        if (runs == 4) begin abort = 1'b1; aborted = 1'b1; end
        runs++;
      end
      step();
    end
    abort = 1'b0;
    check("abort_reached", aborted, 1'b1);
    check("abort_state", {busy, done, timeout, host_grant}, {1'b0, 1'b0, 1'b0, 1'b1});

    // abort while in REQ
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 10 && !core_req; i++) step();
    check("req_seen", core_req, 1'b1);
    abort = 1'b1; step(); abort = 1'b0;
    check("abort_req", {busy, core_req, host_grant}, {1'b0, 1'b0, 1'b1});

    // reset in the middle of RUN
    runs = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 20 && runs < 4; i++) begin
      if (in_run()) runs++;
      step();
    end
    check("pre_reset_cc", cycle_count, 4);
    Reset = 1'b1; step(); Reset = 1'b0;
    check("reset_run", {busy, done, timeout, host_grant, cycle_count}, {1'b0, 1'b0, 1'b0, 1'b1, 16'd0});

    // ack on the same cycle the count reaches MAX-1
    runs = 0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 300 && !(done || timeout); i++) begin
      if (in_run()) begin core_ack = (runs == MAX - 1); runs++; end
      step();
    end
    core_ack = 1'b0;
    check("edge_done", {done, timeout}, {1'b1, 1'b0});
    check("edge_cycles", cycle_count, MAX - 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
